execute_stage: RTL

Execute stage of the pipelined Thumb-subset core. It consumes the decode/execution pipeline register outputs and selects operands. It computes the ALU result, maintains the NZCV flag register, and runs a multi-cycle iterative multiplier that stalls upstream stages. Results and destination info are registered for the execution/memory register.

---
 rtl/execute_stage.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// Execute stage of the Thumb-subset pipeline: operand mux, ALU, NZCV flag register and multiplier.
// Define ITERATIVE_MUL_EN for the stalling shift-add multiplier; otherwise MUL completes in one cycle.

package execute_pkg;
  localparam int WORD = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_ORR = 4'd3,
    ALU_EOR = 4'd4,
    ALU_LSL = 4'd5,
    ALU_LSR = 4'd6,
    ALU_ASR = 4'd7,
    ALU_MOV = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_t;

  typedef enum logic {FROM_REG = 1'b0, FROM_IMM = 1'b1} alu_input_source;
  typedef enum logic {NO_UPDATE_FLAG = 1'b0, UPDATE_FLAG = 1'b1} update_flag_sig;
  typedef enum logic {NO_REG_WRITE = 1'b0, REG_WRITE = 1'b1} reg_file_write_sig;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mul_state_t;
endpackage

module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_WIDTH = WORD,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [3:0]            alu_op_i,
  input  logic                  alu_input_1_select_i,
  input  logic                  alu_input_2_select_i,
  input  logic                  update_flag_i,
  input  logic [4:0]            accumulator_imm_i,
  input  logic [DATA_WIDTH-1:0] reg_1_data_i,
  input  logic [DATA_WIDTH-1:0] reg_2_data_i,
  input  logic [DATA_WIDTH-1:0] immediate_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic                  reg_file_write_en_i,
  output logic                  stall_o,
  output logic                  result_valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic                  reg_file_write_en_o,
  output logic [3:0]            flags_o
);

  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] op1, op2, alu_res;
  logic [DATA_WIDTH:0]   add_wide, sh_wide;
  logic                  c_new, v_new;
  logic [3:0]            nzcv_new;
  logic                  idle, accept, single_accept;

  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  we_q, we_d;
  logic [3:0]            flags_q, flags_d;

  assign op1    = (alu_input_1_select_i == FROM_REG) ? reg_1_data_i : immediate_i;
  assign op2    = (alu_input_2_select_i == FROM_REG) ? reg_2_data_i : immediate_i;
  assign accept = valid_i && !flush_i && idle;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    add_wide = '0;
    sh_wide  = '0;
    alu_res  = '0;
    c_new    = flags_q[1];
    v_new    = flags_q[0];
    case (alu_op_i)
      ALU_ADD: begin
        add_wide = {1'b0, op1} + {1'b0, op2};
        alu_res  = add_wide[MSB:0];
        c_new    = add_wide[DATA_WIDTH];
        v_new    = (op1[MSB] == op2[MSB]) && (alu_res[MSB] != op1[MSB]);
      end
      ALU_SUB: begin
        // Two's-complement subtract: carry out of op1 + ~op2 + 1 is NOT borrow.
        add_wide = {1'b0, op1} + {1'b0, ~op2} + {{DATA_WIDTH{1'b0}}, 1'b1};
        alu_res  = add_wide[MSB:0];
        c_new    = add_wide[DATA_WIDTH];
        v_new    = (op1[MSB] != op2[MSB]) && (alu_res[MSB] != op1[MSB]);
      end
      ALU_AND: alu_res = op1 & op2;
      ALU_ORR: alu_res = op1 | op2;
      ALU_EOR: alu_res = op1 ^ op2;
      ALU_MOV: alu_res = op2;
      ALU_LSL: begin
        sh_wide = {1'b0, op1} << accumulator_imm_i;
        alu_res = sh_wide[MSB:0];
        if (accumulator_imm_i != '0) c_new = sh_wide[DATA_WIDTH];
      end
      ALU_LSR: begin
        sh_wide = {op1, 1'b0} >> accumulator_imm_i;
        alu_res = sh_wide[DATA_WIDTH:1];
        if (accumulator_imm_i != '0) c_new = sh_wide[0];
      end
      ALU_ASR: begin
        sh_wide = $unsigned($signed({op1, 1'b0}) >>> accumulator_imm_i);
        alu_res = sh_wide[DATA_WIDTH:1];
        if (accumulator_imm_i != '0) c_new = sh_wide[0];
      end
`ifndef ITERATIVE_MUL_EN
      ALU_MUL: alu_res = op1 * op2;
`endif
      default: alu_res = '0;
    endcase
    nzcv_new = {alu_res[MSB], alu_res == '0, c_new, v_new};
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      dest_q   <= '0;
      we_q     <= NO_REG_WRITE;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
      dest_q   <= dest_d;
      we_q     <= we_d;
      flags_q  <= flags_d;
    end
  end

`ifdef ITERATIVE_MUL_EN
  localparam int CNT_W = $clog2(DATA_WIDTH);

  mul_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] pend_dest_q, pend_dest_d;
  logic                  pend_upd_q, pend_upd_d, pend_we_q, pend_we_d;
  logic                  is_mul, mul_start, mul_last;

  assign idle          = (state_q == IDLE);
  assign is_mul        = (alu_op_i == ALU_MUL);
  assign mul_start     = accept && is_mul;
  assign single_accept = accept && !is_mul;
  assign acc_sum       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last      = (state_q == BUSY) && !flush_i && (count_q == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mul_start) state_d = BUSY;
      BUSY:    if (flush_i || mul_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o = (state_q == BUSY);
  end

  always_comb begin
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    pend_dest_d = pend_dest_q;
    pend_upd_d  = pend_upd_q;
    pend_we_d   = pend_we_q;
    if (mul_start) begin
      mcand_d     = op1;
      mplier_d    = op2;
      acc_d       = '0;
      count_d     = '0;
      pend_dest_d = reg_dest_addr_i;
      pend_upd_d  = (update_flag_i == UPDATE_FLAG);
      pend_we_d   = reg_file_write_en_i;
    end else if ((state_q == BUSY) && !flush_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
    end
  end

  // NOTE: the multiplier working registers are reset as well, so no X survives an aborted multiply.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      pend_dest_q <= '0;
      pend_upd_q  <= 1'b0;
      pend_we_q   <= NO_REG_WRITE;
    end else begin
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      pend_dest_q <= pend_dest_d;
      pend_upd_q  <= pend_upd_d;
      pend_we_q   <= pend_we_d;
    end
  end
`else
  assign idle          = 1'b1;
  assign single_accept = accept;
  assign stall_o       = 1'b0;
`endif

  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    dest_d   = dest_q;
    we_d     = we_q;
    flags_d  = flags_q;
    if (single_accept) begin
      result_d = alu_res;
      valid_d  = 1'b1;
      dest_d   = reg_dest_addr_i;
      we_d     = reg_file_write_en_i;
      if (update_flag_i == UPDATE_FLAG) flags_d = nzcv_new;
    end
`ifdef ITERATIVE_MUL_EN
    if (mul_last) begin
      result_d = acc_sum;
      valid_d  = 1'b1;
      dest_d   = pend_dest_q;
      we_d     = pend_we_q;
      if (pend_upd_q) flags_d = {acc_sum[MSB], acc_sum == '0, flags_q[1:0]};
    end
`endif
  end

  assign result_o            = result_q;
  assign result_valid_o      = valid_q;
  assign reg_dest_addr_o     = dest_q;
  assign reg_file_write_en_o = we_q;
  assign flags_o             = flags_q;

endmodule
